// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch buffer
package fetch_pkg;

    localparam int FETCH_BUF_DEPTH = 4;
    localparam int FETCH_XLEN      = 32;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  exc;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        FB_RUN  = 1'b0,
        FB_HOLD = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fetch_buffer_ram.sv
// rtl/fetch_buffer_ram.sv - entry storage, one write port, one asynchronous read port
module fetch_buffer_ram
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [FETCH_ENTRY_W-1:0]   wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [FETCH_ENTRY_W-1:0]   rdata_o
);

    // Data is deliberately left unreset; validity is tracked by the occupancy count.
    logic [FETCH_ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - fetch-to-decode queue with stall, fault hold and flush; FETCH_BUF_BYPASS_EN adds an empty-queue bypass
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH,
    parameter int XLEN  = FETCH_XLEN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    input  logic [XLEN-1:0]          in_pc_i,
    input  logic [XLEN-1:0]          in_instr_i,
    input  logic                     in_exc_i,
    output logic                     out_valid_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [XLEN-1:0]          out_instr_o,
    output logic                     out_exc_o,
    input  logic                     out_ready_i,
    output logic                     stall_fetch_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

    generate
        if (XLEN != FETCH_XLEN) begin : g_xlen_check
            $error("fetch_buffer: XLEN must match fetch_pkg::FETCH_XLEN");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("fetch_buffer: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    fb_state_t        state_q;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             stall_q, stall_d;

    fetch_entry_t               wr_entry;
    fetch_entry_t               rd_entry;
    logic [FETCH_ENTRY_W-1:0]   rd_data;

    logic run;
    logic mem_valid;
    logic pop;
    logic push;
    logic bypass_open;
    logic bypass_take;
    logic accept_exc;

    assign run       = (state_q == FB_RUN);
    assign mem_valid = (count_q != '0);
    assign pop       = mem_valid & out_ready_i;

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass_open = !mem_valid & run & !flush_i;
`else
    assign bypass_open = 1'b0;
`endif

    // A bypassed word that decode takes immediately never touches storage.
    assign bypass_take = bypass_open & in_valid_i & out_ready_i;

    assign push = in_valid_i & !flush_i & run & ((count_q != FULL) | pop) & !bypass_take;

    assign overflow_o = in_valid_i & !flush_i & run & (count_q == FULL) & !pop;

    assign accept_exc = (push | bypass_take) & in_exc_i;

    assign wr_entry = '{pc: in_pc_i, instr: in_instr_i, exc: in_exc_i};
    assign rd_entry = rd_data;

    fetch_buffer_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push & !rst_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Stall looks at the current count, so it lags by a cycle; the spare slot
    // absorbs the word already in flight from instruction memory.
    assign stall_d = (count_q >= ALMOST) | (state_q == FB_HOLD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FB_RUN;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            case (state_q)
                FB_RUN: begin
                    if (accept_exc) begin
                        state_q <= FB_HOLD;
                    end
                end
                FB_HOLD: begin
                    if (flush_i) begin
                        state_q <= FB_RUN;
                    end
                end
                default: state_q <= FB_RUN;
            endcase
        end
    end

    always_comb begin
        out_valid_o = 1'b0;
        out_pc_o    = '0;
        out_instr_o = '0;
        out_exc_o   = 1'b0;
        if (mem_valid) begin
            out_valid_o = 1'b1;
            out_pc_o    = rd_entry.pc;
            out_instr_o = rd_entry.instr;
            out_exc_o   = rd_entry.exc;
        end else if (bypass_open & in_valid_i) begin
            out_valid_o = 1'b1;
            out_pc_o    = in_pc_i;
            out_instr_o = in_instr_i;
            out_exc_o   = in_exc_i;
        end
    end

    assign stall_fetch_o = stall_q;
    assign count_o       = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer against a queue-based reference model
module tb_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_exc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;
    logic        out_ready;
    logic        stall_fetch;
    logic [2:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;

    ent_t q[$];
    bit   m_hold;
    bit   m_stall;

    fetch_buffer #(
        .DEPTH (DEPTH),
        .XLEN  (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_pc_i       (in_pc),
        .in_instr_i    (in_instr),
        .in_exc_i      (in_exc),
        .out_valid_o   (out_valid),
        .out_pc_o      (out_pc),
        .out_instr_o   (out_instr),
        .out_exc_o     (out_exc),
        .out_ready_i   (out_ready),
        .stall_fetch_o (stall_fetch),
        .count_o       (count),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic model_edge();
        int   sz;
        bit   pop_m;
        bit   acc;
        bit   byp;
        bit   stall_n;
        ent_t e;
        sz = q.size();
        if (rst) begin
            q.delete();
            m_hold  = 0;
            m_stall = 0;
        end else begin
            stall_n = (sz >= DEPTH - 1) || m_hold;
            if (flush) begin
                q.delete();
                m_hold = 0;
            end else begin
                byp = 0;
`ifdef FETCH_BUF_BYPASS_EN
                byp = (sz == 0) && !m_hold && in_valid && out_ready;
`endif
                pop_m = (sz != 0) && out_ready;
                acc   = in_valid && !m_hold && (sz < DEPTH || pop_m) && !byp;
                if (pop_m) void'(q.pop_front());
                if (acc) begin
                    e.pc = in_pc; e.instr = in_instr; e.exc = in_exc;
                    q.push_back(e);
                end
                if ((acc || byp) && in_exc) m_hold = 1;
            end
            m_stall = stall_n;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic e,
                         input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = $urandom();
        in_exc    = e;
        out_ready = rdy;
        flush     = fl;
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 32'h1234, 0, 1, 0);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", out_pc); else n_pass++;
        n_checks++; if (out_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", out_instr); else n_pass++;
        n_checks++; if (out_exc !== 1'b0) $display("FAIL reset_exc got %0b want 0", out_exc); else n_pass++;
        n_checks++; if (stall_fetch !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall_fetch); else n_pass++;
        n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else n_pass++;
    endtask

    task automatic test_fill_drain();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1000 + 32'(4 * i), 0, 0, 0);
            n_checks++; if (count !== 3'(i)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); else n_pass++;
            n_checks++; if (stall_fetch !== 1'b0) $display("FAIL fill_stall[%0d] got %0b want 0", i, stall_fetch); else n_pass++;
            tick();
        end
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (count !== 3'd4) $display("FAIL fill_full got %0d want 4", count); else n_pass++;
        n_checks++; if (stall_fetch !== 1'b1) $display("FAIL fill_stall_full got %0b want 1", stall_fetch); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 0, 1, 0);
            n_checks++; if (out_valid !== 1'b1) $display("FAIL drain_valid[%0d] got %0b want 1", i, out_valid); else n_pass++;
            n_checks++; if (out_pc !== 32'h1000 + 32'(4 * i)) $display("FAIL drain_pc[%0d] got %h want %h", i, out_pc, 32'h1000 + 32'(4 * i)); else n_pass++;
            tick();
        end
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (count !== 3'd0) $display("FAIL drain_empty got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_overflow();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1000 + 32'(4 * i), 0, 0, 0);
            tick();
        end
        drive(1, 32'h1010, 0, 0, 0);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got %0b want 1", overflow); else n_pass++;
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %0b want 0", overflow); else n_pass++;
        n_checks++; if (count !== 3'd4) $display("FAIL ovf_count got %0d want 4", count); else n_pass++;
        n_checks++; if (out_pc !== 32'h1000) $display("FAIL ovf_head got %h want 1000", out_pc); else n_pass++;
        drive(1, 32'h1010, 0, 1, 0);
        n_checks++; if (overflow !== 1'b0) $display("FAIL full_pushpop_ovf got %0b want 0", overflow); else n_pass++;
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (count !== 3'd4) $display("FAIL full_pushpop_count got %0d want 4", count); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 0, 1, 0);
            n_checks++; if (out_pc !== 32'h1004 + 32'(4 * i)) $display("FAIL full_pushpop_pc[%0d] got %h want %h", i, out_pc, 32'h1004 + 32'(4 * i)); else n_pass++;
            tick();
        end
    endtask

    task automatic test_flush();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1000 + 32'(4 * i), 0, 0, 0);
            tick();
        end
        drive(1, 32'h5000, 0, 0, 1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL flush_cycle_valid got %0b want 1", out_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL flush_cycle_ovf got %0b want 0", overflow); else n_pass++;
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (count !== 3'd0) $display("FAIL flush_count got %0d want 0", count); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (stall_fetch !== 1'b1) $display("FAIL flush_stall_lag got %0b want 1", stall_fetch); else n_pass++;
        tick();
        n_checks++; if (stall_fetch !== 1'b0) $display("FAIL flush_stall_clear got %0b want 0", stall_fetch); else n_pass++;
    endtask

    task automatic test_exc_hold();
        reset_dut();
        drive(1, 32'h2000, 1, 0, 0);
        tick();
        drive(1, 32'h2004, 0, 0, 0);
        n_checks++; if (overflow !== 1'b0) $display("FAIL hold_ovf got %0b want 0", overflow); else n_pass++;
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (count !== 3'd1) $display("FAIL hold_count got %0d want 1", count); else n_pass++;
        n_checks++; if (stall_fetch !== 1'b1) $display("FAIL hold_stall got %0b want 1", stall_fetch); else n_pass++;
        drive(0, 32'h0, 0, 1, 0);
        n_checks++; if (out_pc !== 32'h2000) $display("FAIL hold_pc got %h want 2000", out_pc); else n_pass++;
        n_checks++; if (out_exc !== 1'b1) $display("FAIL hold_exc got %0b want 1", out_exc); else n_pass++;
        tick();
        drive(1, 32'h2008, 0, 0, 0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (count !== 3'd0) $display("FAIL hold_ignore got %0d want 0", count); else n_pass++;
        drive(0, 32'h0, 0, 0, 1);
        tick();
        drive(1, 32'h3000, 0, 0, 0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (count !== 3'd1) $display("FAIL hold_release_count got %0d want 1", count); else n_pass++;
        n_checks++; if (out_pc !== 32'h3000) $display("FAIL hold_release_pc got %h want 3000", out_pc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pcs[$];
        logic [31:0] pc;
        logic [31:0] want;
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            pc = 32'h4000 + 32'(4 * i);
            drive(1, pc, 0, 0, 0);
            exp_pcs.push_back(pc);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            pc = 32'h4008 + 32'(4 * k);
            drive(1, pc, 0, 1, 0);
            want = exp_pcs.pop_front();
            exp_pcs.push_back(pc);
            n_checks++; if (out_pc !== want) $display("FAIL b2b_pc[%0d] got %h want %h", k, out_pc, want); else n_pass++;
            n_checks++; if (count !== 3'd2) $display("FAIL b2b_count[%0d] got %0d want 2", k, count); else n_pass++;
            tick();
        end
    endtask

`ifdef FETCH_BUF_BYPASS_EN
    task automatic test_bypass();
        reset_dut();
        drive(1, 32'h1000, 0, 1, 0);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bypass_valid got %0b want 1", out_valid); else n_pass++;
        n_checks++; if (out_pc !== 32'h1000) $display("FAIL bypass_pc got %h want 1000", out_pc); else n_pass++;
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_checks++; if (count !== 3'd0) $display("FAIL bypass_count got %0d want 0", count); else n_pass++;
    endtask
`endif

    task automatic test_random();
        bit   ev;
        bit   eovf;
        ent_t head;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 7, $urandom(), $urandom_range(0, 29) == 0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
            ev = 0;
            head.pc = '0; head.instr = '0; head.exc = 1'b0;
            if (q.size() != 0) begin
                ev = 1;
                head = q[0];
            end
`ifdef FETCH_BUF_BYPASS_EN
            else if (in_valid && !m_hold && !flush) begin
                ev = 1;
                head.pc = in_pc; head.instr = in_instr; head.exc = in_exc;
            end
`endif
            eovf = in_valid && !flush && !m_hold && (q.size() == DEPTH) && !out_ready;
            n_checks++; if (out_valid !== ev) $display("FAIL rnd_valid[%0d] got %0b want %0b", c, out_valid, ev); else n_pass++;
            if (ev) begin
                n_checks++; if (out_pc !== head.pc) $display("FAIL rnd_pc[%0d] got %h want %h", c, out_pc, head.pc); else n_pass++;
                n_checks++; if (out_instr !== head.instr) $display("FAIL rnd_instr[%0d] got %h want %h", c, out_instr, head.instr); else n_pass++;
                n_checks++; if (out_exc !== head.exc) $display("FAIL rnd_exc[%0d] got %0b want %0b", c, out_exc, head.exc); else n_pass++;
            end
            n_checks++; if (count !== 3'(q.size())) $display("FAIL rnd_count[%0d] got %0d want %0d", c, count, q.size()); else n_pass++;
            n_checks++; if (stall_fetch !== m_stall) $display("FAIL rnd_stall[%0d] got %0b want %0b", c, stall_fetch, m_stall); else n_pass++;
            n_checks++; if (overflow !== eovf) $display("FAIL rnd_ovf[%0d] got %0b want %0b", c, overflow, eovf); else n_pass++;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_pc = '0;
        in_instr = '0;
        in_exc = 1'b0;
        out_ready = 1'b0;
        q.delete();
        m_hold = 0;
        m_stall = 0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_flush();
        test_exc_hold();
        test_back_to_back();
`ifdef FETCH_BUF_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
